// File: rtl/ex_mc_if.sv
// Handshake and operand bundle between decode, the ex_mc stage and writeback.
interface ex_mc_if #(
   parameter int XLEN  = 32,
   parameter int IMM_W = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [6:0]       operation;
   logic [2:0]       funct3;
   logic             shift_ctrl;
   logic             sub_ctrl;
   logic             m_ctrl;
   logic [XLEN-1:0]  data_rs1;
   logic [XLEN-1:0]  data_rs2;
   logic [IMM_W-1:0] imm;
   logic [XLEN-1:0]  pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  data_out;
   logic [XLEN-1:0]  jmp_to;
   logic             busy;

   modport master (
      output in_valid, operation, funct3, shift_ctrl, sub_ctrl, m_ctrl,
      output data_rs1, data_rs2, imm, pc, flush, out_ready,
      input  in_ready, out_valid, data_out, jmp_to, busy
   );

   modport slave (
      input  in_valid, operation, funct3, shift_ctrl, sub_ctrl, m_ctrl,
      input  data_rs1, data_rs2, imm, pc, flush, out_ready,
      output in_ready, out_valid, data_out, jmp_to, busy
   );
endinterface

// File: rtl/ex_mc.sv
// Multi-cycle RV execute stage: 1-cycle ALU/jumps, iterative RV32M multiply/divide.
// The divider is built only when EX_MC_DIV_EN is defined.
module ex_mc #(
   parameter int XLEN  = 32,
   parameter int IMM_W = 12
) (
   input logic    clk,
   input logic    rst,
   ex_mc_if.slave io
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(XLEN);
   localparam logic [6:0] OPC_OP   = 7'b0110011;
   localparam logic [6:0] OPC_OPI  = 7'b0010011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        f3_q;
   logic              neg_q;
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   b_q;
   logic [2*XLEN-1:0] acc_q;
   logic              ov_q;
   logic              busy_q;
   logic [XLEN-1:0]   data_q;
   logic [XLEN-1:0]   jmp_q;

   logic is_op, is_opi, is_jal, is_jalr;
   logic is_mul, is_div, accept, last;
   logic sgn_a, sgn_b, neg_a, neg_b;
   logic [XLEN-1:0] imm_x, opb, alu_res, ex_data, ex_jmp;
   logic [XLEN-1:0] mag_a, mag_b;
   logic signed [XLEN-1:0] sra_res;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_acc_d, prod;
   logic [XLEN-1:0]   mul_a_d, mul_res;

   assign is_op   = io.operation == OPC_OP;
   assign is_opi  = io.operation == OPC_OPI;
   assign is_jal  = io.operation == OPC_JAL;
   assign is_jalr = io.operation == OPC_JALR;
   assign is_mul  = is_op & io.m_ctrl & ~io.funct3[2];
   assign is_div  = is_op & io.m_ctrl & io.funct3[2];

   // flush opens in_ready but wins over accept
   assign io.in_ready = (state_q == S_IDLE)
                      | ((state_q == S_DONE) & io.out_ready)
                      | io.flush;
   assign accept = io.in_valid & io.in_ready & ~io.flush;

   assign imm_x   = {{(XLEN-IMM_W){io.imm[IMM_W-1]}}, io.imm};
   assign opb     = is_op ? io.data_rs2 : imm_x;
   assign sra_res = $signed(io.data_rs1) >>> opb[SW-1:0];

   always_comb begin
      alu_res = '0;
      unique case (io.funct3)
         3'b000: alu_res = (is_op & io.sub_ctrl) ? io.data_rs1 - opb
                                                 : io.data_rs1 + opb;
         3'b001: alu_res = io.data_rs1 << opb[SW-1:0];
         3'b010: alu_res = {{(XLEN-1){1'b0}},
                            $signed(io.data_rs1) < $signed(opb)};
         3'b011: alu_res = {{(XLEN-1){1'b0}}, io.data_rs1 < opb};
         3'b100: alu_res = io.data_rs1 ^ opb;
         3'b101: alu_res = io.shift_ctrl ? sra_res
                                         : io.data_rs1 >> opb[SW-1:0];
         3'b110: alu_res = io.data_rs1 | opb;
         3'b111: alu_res = io.data_rs1 & opb;
      endcase
   end

   always_comb begin
      ex_data = '0;
      ex_jmp  = '0;
      unique case (1'b1)
         is_jal: begin
            ex_data = io.pc + XLEN'(4);
            ex_jmp  = io.pc + imm_x;
         end
         is_jalr: begin
            ex_data = io.pc + XLEN'(4);
            ex_jmp  = (io.data_rs1 + imm_x) & ~XLEN'(1);
         end
         is_op | is_opi: ex_data = alu_res;
         default: ;
      endcase
   end

   // unsigned-operand variants: MULHU, DIVU, REMU (a); also MULHSU (b)
   assign sgn_a = ~(io.funct3 == 3'b011 | io.funct3 == 3'b101
                  | io.funct3 == 3'b111);
   assign sgn_b = sgn_a & (io.funct3 != 3'b010);
   assign neg_a = sgn_a & io.data_rs1[XLEN-1];
   assign neg_b = sgn_b & io.data_rs2[XLEN-1];
   assign mag_a = neg_a ? -io.data_rs1 : io.data_rs1;
   assign mag_b = neg_b ? -io.data_rs2 : io.data_rs2;
   assign last  = cnt_q == CW'(XLEN-1);

   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + {1'b0, (a_q[0] ? b_q : '0)};
   assign mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
   assign mul_a_d   = a_q >> 1;
   assign prod      = neg_q ? -mul_acc_d : mul_acc_d;
   assign mul_res   = (f3_q == 3'b000) ? prod[XLEN-1:0]
                                       : prod[2*XLEN-1:XLEN];

`ifdef EX_MC_DIV_EN
   logic            negr_q;
   logic            dz_q;
   logic [XLEN-1:0] dvd_q;
   logic [XLEN:0]   rem_sh, div_rem_d;
   logic [XLEN+1:0] div_diff;
   logic            div_ge;
   logic [XLEN-1:0] div_quo_d, q_fix, r_fix, div_res;

   assign rem_sh    = {acc_q[XLEN-1:0], a_q[XLEN-1]};
   assign div_diff  = {1'b0, rem_sh} - {2'b0, b_q};
   assign div_ge    = ~div_diff[XLEN+1];
   assign div_rem_d = div_ge ? div_diff[XLEN:0] : rem_sh;
   assign div_quo_d = {a_q[XLEN-2:0], div_ge};
   assign q_fix = dz_q  ? '1
                : neg_q ? -div_quo_d : div_quo_d;
   assign r_fix = dz_q   ? dvd_q
                : negr_q ? -div_rem_d[XLEN-1:0] : div_rem_d[XLEN-1:0];
   assign div_res = f3_q[1] ? r_fix : q_fix;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         negr_q <= 1'b0;
         dz_q   <= 1'b0;
         dvd_q  <= '0;
      end else if (accept) begin
         negr_q <= neg_a;
         dz_q   <= io.data_rs2 == '0;
         dvd_q  <= io.data_rs1;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         jmp_q   <= '0;
      end else if (io.flush) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else if (accept) begin
         cnt_q <= '0;
         acc_q <= '0;
         f3_q  <= io.funct3;
         neg_q <= neg_a ^ neg_b;
         a_q   <= mag_a;
         b_q   <= mag_b;
         if (is_mul) begin
            state_q <= S_MUL;
            busy_q  <= 1'b1;
            ov_q    <= 1'b0;
         end else if (is_div) begin
`ifdef EX_MC_DIV_EN
            state_q <= S_DIV;
            busy_q  <= 1'b1;
            ov_q    <= 1'b0;
`else
            state_q <= S_DONE;
            ov_q    <= 1'b1;
            data_q  <= '0;
            jmp_q   <= '0;
`endif
         end else begin
            state_q <= S_DONE;
            ov_q    <= 1'b1;
            data_q  <= ex_data;
            jmp_q   <= ex_jmp;
         end
      end else begin
         unique case (state_q)
            S_MUL: begin
               acc_q <= mul_acc_d;
               a_q   <= mul_a_d;
               cnt_q <= cnt_q + CW'(1);
               if (last) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  ov_q    <= 1'b1;
                  data_q  <= mul_res;
                  jmp_q   <= '0;
               end
            end
`ifdef EX_MC_DIV_EN
            S_DIV: begin
               acc_q <= {{(XLEN-1){1'b0}}, div_rem_d};
               a_q   <= div_quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (last) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  ov_q    <= 1'b1;
                  data_q  <= div_res;
                  jmp_q   <= '0;
               end
            end
`endif
            S_DONE: begin
               if (io.out_ready) begin
                  state_q <= S_IDLE;
                  ov_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign io.out_valid = ov_q;
   assign io.data_out  = data_q;
   assign io.jmp_to    = jmp_q;
   assign io.busy      = busy_q;
endmodule
